// File: rtl/dmx_framer_if.sv
// Host write/control signals and serial-line status of the DMX512 framer.
interface dmx_framer_if;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       go;
    logic       continuous;
    logic       dmx_data;
    logic       busy;
    logic       frame_done;
    logic [9:0] slot_index;

    modport master (output wr_en, wr_addr, wr_data, go, continuous,
                    input  dmx_data, busy, frame_done, slot_index);
    modport slave  (input  wr_en, wr_addr, wr_data, go, continuous,
                    output dmx_data, busy, frame_done, slot_index);
endinterface

// File: rtl/dmx_framer.sv
// DMX512 frame transmitter: BREAK, MAB, start code, then NUM_SLOTS 8N2 slots
// taken from a host-written slot array; single-shot or back-to-back frames.
//
// state | meaning
// IDLE  | line at mark, waiting for go or continuous
// BREAK | line low for BREAK_BITS bit times
// MAB   | mark-after-break, MAB_BITS bit times
// START | start bit of the current slot (byte latched on entry)
// DATA  | eight data bits, LSB first
// STOP  | two stop bits at mark
// MTBF  | extra mark time before the next BREAK
module dmx_framer #(
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned BAUD       = 250_000,
    parameter int unsigned NUM_SLOTS  = 512,
    parameter int unsigned BREAK_BITS = 22,
    parameter int unsigned MAB_BITS   = 3,
    parameter int unsigned MTBF_BITS  = 0,
    parameter logic [7:0]  START_CODE = 8'h00
) (
    input logic         CLK12,
    input logic         RESET,
    dmx_framer_if.slave dmx
);
    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(NUM_SLOTS + 1);

    localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
    localparam logic [9:0]    LAST_SLOT = 10'(NUM_SLOTS);
    localparam logic [15:0]   BREAK_M1  = 16'(BREAK_BITS - 1);
    localparam logic [15:0]   MAB_M1    = 16'(MAB_BITS - 1);
    localparam logic [15:0]   MTBF_M1   = 16'(MTBF_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BREAK, S_MAB, S_START, S_DATA, S_STOP, S_MTBF
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   bits_q;
    logic [9:0]    slot_q;
    logic [7:0]    shift_q;
    logic          line_q;
    logic          busy_q;
    logic          done_q;

    logic [7:0]    slot_mem [0:NUM_SLOTS];
    logic [9:0]    next_slot_d;
    logic [7:0]    next_byte_d;
    logic          last_bit;
    logic          frame_end;
    logic          done_d;

    // Entry 0 is never written: slot 0 always carries START_CODE.
    always_ff @(posedge CLK12) begin
        if (dmx.wr_en && dmx.wr_addr != 10'd0 && dmx.wr_addr <= LAST_SLOT)
            slot_mem[dmx.wr_addr[AW-1:0]] <= dmx.wr_data;
    end

    always_comb begin
        next_slot_d = slot_q + 10'd1;
        next_byte_d = slot_mem[next_slot_d[AW-1:0]];
        last_bit    = 1'b0;
        if (state_q == S_MTBF)
            last_bit = (bits_q == 16'd0);
        else if (state_q == S_STOP && MTBF_BITS == 0)
            last_bit = (bits_q == 16'd0) && (slot_q == LAST_SLOT);
        frame_end = last_bit && (cnt_q == '0);
        // Registered pulse lands on the final cycle of the frame.
        done_d    = last_bit && (cnt_q == CW'(1));
    end

    always_ff @(posedge CLK12 or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bits_q  <= 16'd0;
            slot_q  <= 10'd0;
            shift_q <= 8'h00;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            if (state_q == S_IDLE) begin
                if (dmx.go || dmx.continuous) begin
                    state_q <= S_BREAK;
                    cnt_q   <= DIV_M1;
                    bits_q  <= BREAK_M1;
                    line_q  <= 1'b0;
                    busy_q  <= 1'b1;
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end else begin
                cnt_q <= DIV_M1;
                if (frame_end) begin
                    if (dmx.continuous) begin
                        state_q <= S_BREAK;
                        bits_q  <= BREAK_M1;
                        line_q  <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        line_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end else if (bits_q != 16'd0) begin
                    bits_q <= bits_q - 16'd1;
                    if (state_q == S_DATA) begin
                        line_q  <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end
                end else begin
                    case (state_q)
                        S_BREAK: begin
                            state_q <= S_MAB;
                            bits_q  <= MAB_M1;
                            line_q  <= 1'b1;
                        end
                        S_MAB: begin
                            state_q <= S_START;
                            bits_q  <= 16'd0;
                            slot_q  <= 10'd0;
                            shift_q <= START_CODE;
                            line_q  <= 1'b0;
                        end
                        S_START: begin
                            state_q <= S_DATA;
                            bits_q  <= 16'd7;
                            line_q  <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                        S_DATA: begin
                            state_q <= S_STOP;
                            bits_q  <= 16'd1;
                            line_q  <= 1'b1;
                        end
                        S_STOP: begin
                            if (slot_q != LAST_SLOT) begin
                                state_q <= S_START;
                                bits_q  <= 16'd0;
                                slot_q  <= next_slot_d;
                                shift_q <= next_byte_d;
                                line_q  <= 1'b0;
                            end else begin
                                state_q <= S_MTBF;
                                bits_q  <= MTBF_M1;
                                line_q  <= 1'b1;
                            end
                        end
                        default: begin
                            state_q <= S_IDLE;
                            line_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign dmx.dmx_data   = line_q;
    assign dmx.busy       = busy_q;
    assign dmx.frame_done = done_q;
    assign dmx.slot_index = slot_q;
endmodule

// File: tb/tb_dmx_framer.sv
// Scoreboard bench for dmx_framer: two instances (MTBF 0 single-shot, MTBF 2 continuous).
module tb_dmx_framer;
    localparam int DIV      = 48;
    localparam int SLOT_CYC = 11 * DIV;
    localparam int BRK_CYC  = 22 * DIV;
    localparam int MAB_CYC  = 3 * DIV;
    localparam int FRAME_A  = 3312;
    localparam int FRAME_B  = 3408;

    logic        CLK12 = 1'b0;
    logic        RESET = 1'b1;
    int unsigned cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [7:0]  byte_q [$];
    int unsigned fd_q   [$];
    int unsigned brk_q  [$];
    int unsigned fdb_q  [$];

    dmx_framer_if a_if ();
    dmx_framer_if b_if ();

    dmx_framer #(.CLK_HZ(12_000_000), .BAUD(250_000), .NUM_SLOTS(3), .BREAK_BITS(22),
                 .MAB_BITS(3), .MTBF_BITS(0), .START_CODE(8'h00))
        dut_a (.CLK12(CLK12), .RESET(RESET), .dmx(a_if));

    dmx_framer #(.CLK_HZ(12_000_000), .BAUD(250_000), .NUM_SLOTS(3), .BREAK_BITS(22),
                 .MAB_BITS(3), .MTBF_BITS(2), .START_CODE(8'h00))
        dut_b (.CLK12(CLK12), .RESET(RESET), .dmx(b_if));

    always #5 CLK12 = ~CLK12;
    always @(posedge CLK12) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge CLK12);
    endtask

    task automatic wr_a(input logic [9:0] addr, input logic [7:0] data);
        a_if.wr_en = 1'b1; a_if.wr_addr = addr; a_if.wr_data = data;
        @(negedge CLK12);
        a_if.wr_en = 1'b0;
    endtask

    task automatic wr_b(input logic [9:0] addr, input logic [7:0] data);
        b_if.wr_en = 1'b1; b_if.wr_addr = addr; b_if.wr_data = data;
        @(negedge CLK12);
        b_if.wr_en = 1'b0;
    endtask

    task automatic start_a(input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3,
                           output int unsigned n);
        n = cyc;
        byte_q.push_back(8'h00);
        byte_q.push_back(s1);
        byte_q.push_back(s2);
        byte_q.push_back(s3);
        fd_q.push_back(n + FRAME_A);
        a_if.go = 1'b1;
        @(negedge CLK12);
        a_if.go = 1'b0;
    endtask

    // Line receiver and frame_done monitor for instance A.
    typedef enum {R_IDLE, R_BRK, R_MAB, R_SLOT} rx_t;
    rx_t        rx = R_IDLE;
    int         rlen = 0;
    int         rpos = 0;
    int         rslot = 0;
    logic [7:0] rbyte = 8'h00;
    logic       chk_busy = 1'b0;

    always @(negedge CLK12) begin
        if (RESET) begin
            rx = R_IDLE;
            chk_busy = 1'b0;
        end else begin
            if (chk_busy) begin
                check("a_busy_after_done", a_if.busy, 0);
                chk_busy = 1'b0;
            end
            if (a_if.frame_done) begin
                check("a_frame_done_pending", fd_q.size() != 0, 1);
                if (fd_q.size() != 0) check("a_frame_done_cycle", cyc, fd_q.pop_front());
                chk_busy = 1'b1;
            end
            case (rx)
                R_IDLE: if (!a_if.dmx_data) begin rx = R_BRK; rlen = 1; end
                R_BRK: begin
                    if (!a_if.dmx_data) rlen++;
                    else begin check("a_break_len", rlen, BRK_CYC); rx = R_MAB; rlen = 1; end
                end
                R_MAB: begin
                    if (a_if.dmx_data) rlen++;
                    else begin
                        check("a_mab_len", rlen, MAB_CYC);
                        rx = R_SLOT; rpos = 1; rslot = 0; rbyte = 8'h00;
                    end
                end
                R_SLOT: begin
                    rpos++;
                    if (rpos == DIV / 2)
                        check("a_start_bit", a_if.dmx_data, 0);
                    else if (rpos > DIV && rpos <= 9 * DIV && (rpos % DIV) == DIV / 2)
                        rbyte = {a_if.dmx_data, rbyte[7:1]};
                    else if (rpos == 9 * DIV + DIV / 2 || rpos == 10 * DIV + DIV / 2)
                        check("a_stop_bit", a_if.dmx_data, 1);
                    if (rpos == SLOT_CYC) begin
                        check("a_slot_pending", byte_q.size() != 0, 1);
                        if (byte_q.size() != 0) check("a_slot_byte", rbyte, byte_q.pop_front());
                        rslot++;
                        rbyte = 8'h00;
                        if (rslot == 4) rx = R_IDLE;
                        else rpos = 0;
                    end
                end
                default: rx = R_IDLE;
            endcase
        end
    end

    // BREAK detector and frame_done monitor for instance B.
    int          b_run = 0;
    int unsigned b_run_start = 0;

    always @(negedge CLK12) begin
        if (RESET) begin
            b_run = 0;
        end else begin
            if (!b_if.dmx_data) begin
                if (b_run == 0) b_run_start = cyc;
                b_run++;
                if (b_run == BRK_CYC) begin
                    check("b_break_pending", brk_q.size() != 0, 1);
                    if (brk_q.size() != 0) check("b_break_start", b_run_start, brk_q.pop_front());
                end
            end else begin
                b_run = 0;
            end
            if (b_if.frame_done) begin
                check("b_frame_done_pending", fdb_q.size() != 0, 1);
                if (fdb_q.size() != 0) check("b_frame_done_cycle", cyc, fdb_q.pop_front());
            end
        end
    end

    initial begin
        int unsigned n;
        a_if.wr_en = 1'b0; a_if.wr_addr = 10'd0; a_if.wr_data = 8'h00;
        a_if.go = 1'b0; a_if.continuous = 1'b0;
        b_if.wr_en = 1'b0; b_if.wr_addr = 10'd0; b_if.wr_data = 8'h00;
        b_if.go = 1'b0; b_if.continuous = 1'b0;
        repeat (3) @(negedge CLK12);
        check("a_rst_dmx", a_if.dmx_data, 1);
        check("a_rst_busy", a_if.busy, 0);
        check("a_rst_done", a_if.frame_done, 0);
        check("a_rst_slot_index", a_if.slot_index, 0);
        check("b_rst_dmx", b_if.dmx_data, 1);
        check("b_rst_busy", b_if.busy, 0);
        RESET = 1'b0;
        @(negedge CLK12);

        wr_a(10'd1, 8'hA5); wr_a(10'd2, 8'h01); wr_a(10'd3, 8'hFF);
        wr_b(10'd1, 8'hFF); wr_b(10'd2, 8'hFF); wr_b(10'd3, 8'hFF);
        repeat (2) @(negedge CLK12);

        // Frame 1: timing, byte content and slot_index progression.
        start_a(8'hA5, 8'h01, 8'hFF, n);
        check("a_break_dmx", a_if.dmx_data, 0);
        check("a_break_busy", a_if.busy, 1);
        for (int k = 0; k < 4; k++) begin
            wait_until(n + BRK_CYC + MAB_CYC + k * SLOT_CYC + 10);
            check("a_slot_index", a_if.slot_index, k);
        end
        wait_until(n + FRAME_A + 20);

        // Frame 2: go during BREAK ignored, slot 2 rewritten mid-slot, bad addresses.
        start_a(8'hA5, 8'h01, 8'hFF, n);
        wait_until(n + 10);
        a_if.go = 1'b1;
        @(negedge CLK12);
        a_if.go = 1'b0;
        wait_until(n + 2400);
        wr_a(10'd2, 8'h3C);
        wr_a(10'd0, 8'h77);
        wr_a(10'd4, 8'h77);
        wr_a(10'd5, 8'h77);
        wr_a(10'd1023, 8'h77);
        wait_until(n + FRAME_A + 200);
        check("a_idle_after_ignored_go", a_if.busy, 0);

        // Frame 3: new slot 2 value takes effect.
        start_a(8'hA5, 8'h3C, 8'hFF, n);
        wait_until(n + FRAME_A + 20);

        // Continuous on B: three frames, continuous dropped during the third.
        n = cyc;
        b_if.continuous = 1'b1;
        for (int k = 0; k < 3; k++) begin
            brk_q.push_back(n + 1 + k * FRAME_B);
            fdb_q.push_back(n + (k + 1) * FRAME_B);
        end
        wait_until(n + FRAME_B);
        check("b_busy_frame_end", b_if.busy, 1);
        wait_until(n + FRAME_B + 1);
        check("b_busy_back_to_back", b_if.busy, 1);
        wait_until(n + 2 * FRAME_B + 1000);
        b_if.continuous = 1'b0;
        wait_until(n + 3 * FRAME_B + 1);
        check("b_busy_after_last", b_if.busy, 0);
        check("b_dmx_after_last", b_if.dmx_data, 1);
        wait_until(n + 3 * FRAME_B + 2000);

        // Frame 4 on A: async reset mid-DATA of slot 1.
        n = cyc;
        byte_q.push_back(8'h00);
        a_if.go = 1'b1;
        @(negedge CLK12);
        a_if.go = 1'b0;
        wait_until(n + BRK_CYC + MAB_CYC + SLOT_CYC + 200);
        #2 RESET = 1'b1;
        #1;
        check("a_async_rst_dmx", a_if.dmx_data, 1);
        check("a_async_rst_busy", a_if.busy, 0);
        check("a_async_rst_done", a_if.frame_done, 0);
        repeat (3) @(negedge CLK12);
        RESET = 1'b0;
        repeat (5) @(negedge CLK12);

        // Frame 5: full frame after reset, slot array preserved.
        start_a(8'hA5, 8'h3C, 8'hFF, n);
        wait_until(n + FRAME_A + 20);

        check("a_bytes_left", byte_q.size(), 0);
        check("a_done_left", fd_q.size(), 0);
        check("b_breaks_left", brk_q.size(), 0);
        check("b_done_left", fdb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
